// File: rtl/unidade_controle_niveis.sv
// unidade_controle_niveis: Moore game-control FSM for the drone game.
// Tracks lives and level progression and supports a pause mode.
// The game always starts at level 0 with N_VIDAS lives.
// Optional build macro: VIDA_EXTRA_EN. When defined, the player gains one
// life when advancing to the next level, saturating at N_VIDAS.
module unidade_controle_niveis #(
  parameter int N_VIDAS  = 3,
  parameter int N_NIVEIS = 4,
  parameter int VW       = 4,
  parameter int NW       = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          pausar,
  input  logic          fim_espera,
  input  logic          fim_mapa,
  input  logic          colisao,
  output logic          zeraPosicoes,
  output logic          contaT,
  output logic          zeraT,
  output logic          desloca,
  output logic          perdeu_vida,
  output logic          pausado,
  output logic          venceu,
  output logic          perdeu,
  output logic [NW-1:0] nivel,
  output logic [VW-1:0] vidas,
  output logic [3:0]    db_estado
);

  // The enum values are the codes shown on the debug display.
  typedef enum logic [3:0] {
    ST_INICIAL       = 4'h0,
    ST_PREPARACAO    = 4'h1,
    ST_INICIO_RODADA = 4'h2,
    ST_ESPERA        = 4'h3,
    ST_DESLOCAMENTO  = 4'h4,
    ST_CHECA_COLISAO = 4'h5,
    ST_PROXIMO       = 4'h6,
    ST_DERROTA       = 4'h7,
    ST_VITORIA       = 4'h8,
    ST_PERDA_VIDA    = 4'h9,
    ST_PROX_NIVEL    = 4'hA,
    ST_PAUSA         = 4'hB
  } estado_t;

  localparam logic [VW-1:0] VIDAS_INI = VW'(N_VIDAS);
  localparam logic [NW-1:0] ULTIMO    = NW'(N_NIVEIS - 1);

  estado_t estado;
  estado_t estado_prox;

  logic ultimo_nivel;
  logic ultima_vida;

  assign ultimo_nivel = (nivel == ULTIMO);
  assign ultima_vida  = (vidas <= VW'(1));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= ST_INICIAL;
    else       estado <= estado_prox;
  end

  // Next-state decode; inputs matter only in their decision states.
  always_comb begin
    estado_prox = ST_INICIAL;
    case (estado)
      ST_INICIAL, ST_DERROTA, ST_VITORIA:
        estado_prox = iniciar ? ST_PREPARACAO : estado;
      ST_PREPARACAO:    estado_prox = ST_INICIO_RODADA;
      ST_INICIO_RODADA: estado_prox = ST_ESPERA;
      ST_ESPERA: begin
        // A pause request beats an expiring timer in the same cycle.
        if (pausar)          estado_prox = ST_PAUSA;
        else if (fim_espera) estado_prox = ST_DESLOCAMENTO;
        else                 estado_prox = ST_ESPERA;
      end
      ST_PAUSA: begin
        if (iniciar)     estado_prox = ST_PREPARACAO;
        else if (pausar) estado_prox = ST_ESPERA;
        else             estado_prox = ST_PAUSA;
      end
      ST_DESLOCAMENTO:  estado_prox = ST_CHECA_COLISAO;
      ST_CHECA_COLISAO: begin
        if (!colisao)         estado_prox = ST_PROXIMO;
        else if (ultima_vida) estado_prox = ST_DERROTA;
        else                  estado_prox = ST_PERDA_VIDA;
      end
      ST_PERDA_VIDA:    estado_prox = ST_INICIO_RODADA;
      ST_PROXIMO: begin
        if (!fim_mapa)        estado_prox = ST_INICIO_RODADA;
        else if (ultimo_nivel) estado_prox = ST_VITORIA;
        else                   estado_prox = ST_PROX_NIVEL;
      end
      ST_PROX_NIVEL:    estado_prox = ST_INICIO_RODADA;
      default:          estado_prox = ST_INICIAL;
    endcase
  end

  // Lives and level counters, updated on the edge leaving their state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vidas <= VIDAS_INI;
      nivel <= '0;
    end else begin
      case (estado)
        ST_PREPARACAO: begin
          vidas <= VIDAS_INI;
          nivel <= '0;
        end
        ST_CHECA_COLISAO: begin
          if (colisao && vidas != '0) vidas <= vidas - VW'(1);
        end
        ST_PROXIMO: begin
          if (fim_mapa && !ultimo_nivel) begin
            nivel <= nivel + NW'(1);
`ifdef VIDA_EXTRA_EN
            if (vidas < VIDAS_INI) vidas <= vidas + VW'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Moore output decode; pausa leaves both timer controls low so it holds.
  always_comb begin
    zeraPosicoes = 1'b0;
    contaT       = 1'b0;
    zeraT        = 1'b0;
    desloca      = 1'b0;
    perdeu_vida  = 1'b0;
    pausado      = 1'b0;
    venceu       = 1'b0;
    perdeu       = 1'b0;
    db_estado    = 4'hF;
    case (estado)
      ST_INICIAL: begin
        zeraPosicoes = 1'b1;
        zeraT        = 1'b1;
        db_estado    = 4'h0;
      end
      ST_PREPARACAO: begin
        zeraPosicoes = 1'b1;
        zeraT        = 1'b1;
        db_estado    = 4'h1;
      end
      ST_INICIO_RODADA: begin
        zeraT     = 1'b1;
        db_estado = 4'h2;
      end
      ST_ESPERA: begin
        contaT    = 1'b1;
        db_estado = 4'h3;
      end
      ST_DESLOCAMENTO: begin
        desloca   = 1'b1;
        db_estado = 4'h4;
      end
      ST_CHECA_COLISAO: db_estado = 4'h5;
      ST_PROXIMO: begin
        zeraT     = 1'b1;
        db_estado = 4'h6;
      end
      ST_DERROTA: begin
        perdeu    = 1'b1;
        db_estado = 4'h7;
      end
      ST_VITORIA: begin
        venceu    = 1'b1;
        db_estado = 4'h8;
      end
      ST_PERDA_VIDA: begin
        zeraPosicoes = 1'b1;
        zeraT        = 1'b1;
        perdeu_vida  = 1'b1;
        db_estado    = 4'h9;
      end
      ST_PROX_NIVEL: begin
        zeraPosicoes = 1'b1;
        zeraT        = 1'b1;
        db_estado    = 4'hA;
      end
      ST_PAUSA: begin
        pausado   = 1'b1;
        db_estado = 4'hB;
      end
      default: db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_niveis.sv
// Bench for unidade_controle_niveis: a directed vector table, hand-written
// corner sequences and a randomized run against a behavioural game model.
module tb_unidade_controle_niveis;

  localparam int NV = 3;
  localparam int NN = 4;
`ifdef VIDA_EXTRA_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, pausar = 1'b0, fim_espera = 1'b0;
  logic       fim_mapa = 1'b0, colisao = 1'b0;
  logic       zeraPosicoes, contaT, zeraT, desloca, perdeu_vida;
  logic       pausado, venceu, perdeu;
  logic [3:0] nivel, vidas, db_estado;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  // Clock and reset
  always #5 clock = ~clock;

  unidade_controle_niveis #(.N_VIDAS(NV), .N_NIVEIS(NN), .VW(4), .NW(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar),
    .fim_espera(fim_espera), .fim_mapa(fim_mapa), .colisao(colisao),
    .zeraPosicoes(zeraPosicoes), .contaT(contaT), .zeraT(zeraT),
    .desloca(desloca), .perdeu_vida(perdeu_vida), .pausado(pausado),
    .venceu(venceu), .perdeu(perdeu), .nivel(nivel), .vidas(vidas),
    .db_estado(db_estado)
  );

  assign outs = {zeraPosicoes, zeraT, contaT, desloca, perdeu_vida, pausado, venceu, perdeu};

  // Expected output set per state code:
  // {zeraPosicoes, zeraT, contaT, desloca, perdeu_vida, pausado, venceu, perdeu}
  function automatic logic [7:0] out_tab(input int st);
    case (st)
      0, 1, 10: return 8'b1100_0000;
      2, 6:     return 8'b0100_0000;
      3:        return 8'b0010_0000;
      4:        return 8'b0001_0000;
      7:        return 8'b0000_0001;
      8:        return 8'b0000_0010;
      9:        return 8'b1100_1000;
      11:       return 8'b0000_0100;
      default:  return 8'b0000_0000;
    endcase
  endfunction

  // Scoreboard checks: state code and counters, then the output set.
  task automatic check(input string name, input int st, input int v, input int n);
    logic [7:0] exp_o;
    exp_o = out_tab(st);
    checks++;
    if (db_estado !== 4'(st) || vidas !== 4'(v) || nivel !== 4'(n)) begin
      errors++;
      $display("FAIL %s: estado=%0h vidas=%0d nivel=%0d, expected estado=%0h vidas=%0d nivel=%0d",
               name, db_estado, vidas, nivel, st, v, n);
    end
    checks++;
    if (outs !== exp_o) begin
      errors++;
      $display("FAIL %s outputs: got %b expected %b (state %0h)", name, outs, exp_o, st);
    end
  endtask

  // Driver: apply one cycle of inputs, sample #1 after the edge.
  task automatic step(input logic ini, input logic pau, input logic fe,
                      input logic fm, input logic col);
    iniciar = ini; pausar = pau; fim_espera = fe; fim_mapa = fm; colisao = col;
    @(posedge clock);
    #1;
  endtask

  task automatic sc(input string name, input logic ini, input logic pau, input logic fe,
                    input logic fm, input logic col, input int st, input int v, input int n);
    step(ini, pau, fe, fm, col);
    check(name, st, v, n);
  endtask

  task automatic do_reset();
    iniciar = 0; pausar = 0; fim_espera = 0; fim_mapa = 0; colisao = 0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_async", 0, NV, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_hold", 0, NV, 0);
  endtask

  // Vector table
  typedef struct {
    logic ini, pau, fe, fm, col;
    int   st, v, n;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic ini, input logic pau, input logic fe, input logic fm,
                     input logic col, input int st, input int v, input int n);
    vec_t r;
    r.ini = ini; r.pau = pau; r.fe = fe; r.fm = fm; r.col = col;
    r.st = st; r.v = v; r.n = n;
    vq.push_back(r);
  endtask

  // Behavioural game model
  int ms, mv, mn;

  task automatic model_step(input logic ini, input logic pau, input logic fe,
                            input logic fm, input logic col);
    case (ms)
      0, 7, 8: if (ini) ms = 1;
      1: begin mv = NV; mn = 0; ms = 2; end
      2: ms = 3;
      3: if (pau) ms = 11; else if (fe) ms = 4;
      11: if (ini) ms = 1; else if (pau) ms = 3;
      4: ms = 5;
      5: begin
        if (col) begin
          ms = (mv > 1) ? 9 : 7;
          if (mv > 0) mv = mv - 1;
        end else ms = 6;
      end
      9: ms = 2;
      6: begin
        if (!fm) ms = 2;
        else if (mn == NN - 1) ms = 8;
        else begin
          mn = mn + 1;
          if (EXTRA == 1 && mv < NV) mv = mv + 1;
          ms = 10;
        end
      end
      10: ms = 2;
      default: ms = 0;
    endcase
  endtask

  initial begin
    // Full game, no deaths except one collision in level 1.
    add(1,0,0,0,0, 1, NV, 0);
    add(0,0,0,0,0, 2, NV, 0);
    add(0,0,0,0,0, 3, NV, 0);
    add(0,0,1,0,0, 4, NV, 0);
    add(0,0,0,0,0, 5, NV, 0);
    add(0,0,0,0,0, 6, NV, 0);
    add(0,0,0,1,0, 10, NV, 1);
    add(0,0,0,0,0, 2, NV, 1);
    add(0,0,0,0,0, 3, NV, 1);
    add(0,0,1,0,0, 4, NV, 1);
    add(0,0,0,0,0, 5, NV, 1);
    add(0,0,0,0,1, 9, 2, 1);
    add(0,0,0,0,0, 2, 2, 1);
    add(0,0,0,0,0, 3, 2, 1);
    add(0,0,1,0,0, 4, 2, 1);
    add(0,0,0,0,0, 5, 2, 1);
    add(0,0,0,0,0, 6, 2, 1);
    add(0,0,0,1,0, 10, 2 + EXTRA, 2);
    add(0,0,0,0,0, 2, 2 + EXTRA, 2);
    add(0,0,0,0,0, 3, 2 + EXTRA, 2);
    add(0,0,1,0,0, 4, 2 + EXTRA, 2);
    add(0,0,0,0,0, 5, 2 + EXTRA, 2);
    add(0,0,0,0,0, 6, 2 + EXTRA, 2);
    add(0,0,0,1,0, 10, 2 + EXTRA, 3);
    add(0,0,0,0,0, 2, 2 + EXTRA, 3);
    add(0,0,0,0,0, 3, 2 + EXTRA, 3);
    add(0,0,1,0,0, 4, 2 + EXTRA, 3);
    add(0,0,0,0,0, 5, 2 + EXTRA, 3);
    add(0,0,0,0,0, 6, 2 + EXTRA, 3);
    add(0,0,0,1,0, 8, 2 + EXTRA, 3);
    add(0,1,1,1,1, 8, 2 + EXTRA, 3);
    add(1,0,0,0,0, 1, 2 + EXTRA, 3);
    add(0,0,0,0,0, 2, NV, 0);

    do_reset();
    foreach (vq[i]) begin
      step(vq[i].ini, vq[i].pau, vq[i].fe, vq[i].fm, vq[i].col);
      check($sformatf("vec%0d", i), vq[i].st, vq[i].v, vq[i].n);
    end

    // Lives run out: three collisions end in derrota, then restart.
    do_reset();
    sc("d_prep", 1,0,0,0,0, 1, 3, 0);
    for (int k = 0; k < 3; k++) begin
      sc("d_ini", 0,0,0,0,0, 2, 3 - k, 0);
      sc("d_esp", 0,0,0,0,0, 3, 3 - k, 0);
      sc("d_des", 0,0,1,0,0, 4, 3 - k, 0);
      sc("d_chk", 0,0,0,0,0, 5, 3 - k, 0);
      if (k < 2) sc("d_perda", 0,0,0,0,1, 9, 2 - k, 0);
      else       sc("d_derrota", 0,0,0,0,1, 7, 0, 0);
    end
    sc("d_hold", 0,1,1,1,1, 7, 0, 0);
    sc("d_restart", 1,0,0,0,0, 1, 0, 0);
    sc("d_reload", 0,0,0,0,0, 2, 3, 0);

    // Pause: pausar beats fim_espera, hold, resume, iniciar, reset in pausa.
    do_reset();
    sc("p_prep", 1,0,0,0,0, 1, 3, 0);
    sc("p_ini", 0,0,0,0,0, 2, 3, 0);
    sc("p_esp", 0,0,0,0,0, 3, 3, 0);
    sc("p_pausa", 0,1,1,0,0, 11, 3, 0);
    sc("p_hold", 0,0,1,1,1, 11, 3, 0);
    sc("p_resume", 0,1,1,0,0, 3, 3, 0);
    sc("p_des", 0,0,1,0,0, 4, 3, 0);
    sc("p_chk", 0,0,0,0,0, 5, 3, 0);
    sc("p_col", 0,0,0,0,1, 9, 2, 0);
    sc("p_ini2", 0,0,0,0,0, 2, 2, 0);
    sc("p_esp2", 0,0,0,0,0, 3, 2, 0);
    sc("p_pausa2", 0,1,0,0,0, 11, 2, 0);
    sc("p_iniciar", 1,0,0,0,0, 1, 2, 0);
    sc("p_reload", 0,0,0,0,0, 2, 3, 0);
    sc("p_esp3", 0,0,0,0,0, 3, 3, 0);
    sc("p_pausa3", 0,1,0,0,0, 11, 3, 0);
    pausar = 1'b0;
    reset = 1'b1;
    #1;
    check("p_reset", 0, NV, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Randomized run against the model.
    ms = 0; mv = NV; mn = 0;
    for (int c = 0; c < 4000; c++) begin
      logic ri, rp, rf, rm, rc;
      if ($urandom_range(0, 599) == 0) begin
        iniciar = 0; pausar = 0; fim_espera = 0; fim_mapa = 0; colisao = 0;
        reset = 1'b1;
        #1;
        ms = 0; mv = NV; mn = 0;
        check("rand_reset", ms, mv, mn);
        reset = 1'b0;
      end
      ri = ($urandom_range(0, 19) == 0);
      rp = ($urandom_range(0, 9) == 0);
      rf = $urandom_range(0, 1);
      rm = ($urandom_range(0, 2) == 0);
      rc = ($urandom_range(0, 5) == 0);
      step(ri, rp, rf, rm, rc);
      model_step(ri, rp, rf, rm, rc);
      check($sformatf("rand%0d", c), ms, mv, mn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
